uart_tx_frame_arbiter: RTL and testbench

Shares one UART_TX instance between NUM_REQ byte-stream requesters. Examples are the GPS coordinate packer and a status/debug reporter.
Arbitration is round-robin at frame granularity. Once a requester is granted, it keeps the transmitter until its last byte has finished transmitting.
The block sequences UART_TX with a one-cycle i_Tx_DV pulse per byte and waits for o_Tx_Done. It inserts an optional inter-frame gap, and a watchdog aborts stalled frames.

---
 rtl/uart_tx_frame_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_frame_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin, frame-granular arbiter that shares one UART transmitter between
// NUM_REQ byte streams, with an optional inter-frame gap and a stall watchdog.
module uart_tx_frame_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int GAP_CLKS     = 0,
   parameter int TIMEOUT_CLKS = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_dv,
   output logic [7:0]           tx_byte,
   input  logic                 tx_done,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int MAXC = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CLKS - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CLKS - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP} state_e;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PW-1:0]      g_q, g_d, rr_q, rr_d, g_nxt, pick;
   logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [7:0]         byte_q, byte_d;
   logic               last_q, last_d, terr_q, terr_d, found;
   int                 idx;

   assign g_nxt   = (g_q == PW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   // First valid requester at or above rr_q, wrapping modulo NUM_REQ
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[PW'(idx)]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      g_d     = g_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      last_d  = last_q;
      terr_d  = 1'b0;
      case (state_q)
         S_IDLE: if (found) begin
            grant_d = NUM_REQ'(1) << pick;
            g_d     = pick;
            cnt_d   = '0;
            state_d = S_LOAD;
         end
         S_LOAD: if (req_valid[g_q]) begin
            byte_d  = req_data[8*g_q +: 8];
            last_d  = req_last[g_q];
            state_d = S_SEND;
         end else if (cnt_q >= TO_LAST) begin
            terr_d  = 1'b1;
            rr_d    = g_nxt;
            grant_d = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end else begin
            cnt_d = cnt_inc;
         end
         S_SEND: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         // tx_done is checked first so a byte finishing on the expiry cycle still counts
         S_WAIT: if (tx_done) begin
            cnt_d = '0;
            if (last_q) begin
               rr_d    = g_nxt;
               grant_d = '0;
               state_d = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
            end else begin
               state_d = S_LOAD;
            end
         end else if (cnt_q >= TO_LAST) begin
            terr_d  = 1'b1;
            rr_d    = g_nxt;
            grant_d = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end else begin
            cnt_d = cnt_inc;
         end
         S_GAP: if (cnt_q >= GAP_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end else begin
            cnt_d = cnt_inc;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         g_q     <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         byte_q  <= '0;
         last_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         g_q     <= g_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         last_q  <= last_d;
         terr_q  <= terr_d;
      end
   end

   assign req_ready   = (state_q == S_LOAD) ? grant_q : '0;
   assign tx_dv       = (state_q == S_SEND);
   assign tx_byte     = byte_q;
   assign grant       = grant_q;
   assign busy        = (state_q != S_IDLE);
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench: DUT a (no gap, 16-clock watchdog) and DUT b (5-clock gap),
// each driven by simple requester queues and a fixed-latency UART model.
module tb_uart_tx_frame_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] rv [2];
   logic [15:0] rdat [2];
   logic [1:0] rlst [2];
   logic [1:0] rrdy [2];
   logic       dv [2];
   logic [7:0] txb [2];
   logic       done [2];
   logic [1:0] gnt [2];
   logic       bsy [2];
   logic       terr [2];

   uart_tx_frame_arbiter #(.NUM_REQ(2), .GAP_CLKS(0), .TIMEOUT_CLKS(16)) u_dut_a (
      .clk(clk), .rst(rst), .req_valid(rv[0]), .req_data(rdat[0]), .req_last(rlst[0]),
      .req_ready(rrdy[0]), .tx_dv(dv[0]), .tx_byte(txb[0]), .tx_done(done[0]),
      .grant(gnt[0]), .busy(bsy[0]), .timeout_err(terr[0]));

   uart_tx_frame_arbiter #(.NUM_REQ(2), .GAP_CLKS(5), .TIMEOUT_CLKS(16)) u_dut_b (
      .clk(clk), .rst(rst), .req_valid(rv[1]), .req_data(rdat[1]), .req_last(rlst[1]),
      .req_ready(rrdy[1]), .tx_dv(dv[1]), .tx_byte(txb[1]), .tx_done(done[1]),
      .grant(gnt[1]), .busy(bsy[1]), .timeout_err(terr[1]));

   // requester r = dut*2 + k
   logic [8:0] fm [4][16];
   int         fcnt [4];
   int         fptr [4];
   bit         hs [4];
   logic [7:0] lg [2][32];
   int         lgn [2];
   int         dcnt [2];
   int         ddly [2];
   bit         uon [2];
   int         fdv [2], ldv [2], fdone [2], tcyc [2], nterr [2], gapc [2], g1cyc [2];
   logic [1:0] gor [2];
   int         cyc_n, total, bad, s;
   logic [7:0] exp2 [8];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 2; k++) begin
            int r = d * 2 + k;
            if (fptr[r] < fcnt[r]) begin
               rv[d][k]          = 1'b1;
               rdat[d][8*k +: 8] = fm[r][fptr[r]][7:0];
               rlst[d][k]        = fm[r][fptr[r]][8];
            end else begin
               rv[d][k]          = 1'b0;
               rdat[d][8*k +: 8] = 8'h00;
               rlst[d][k]        = 1'b0;
            end
         end
   endtask

   task automatic push(input int r, input logic last, input logic [7:0] b);
      fm[r][fcnt[r]] = {last, b};
      fcnt[r]++;
   endtask

   task automatic clr();
      for (int d = 0; d < 2; d++) begin
         lgn[d] = 0; fdv[d] = -1; ldv[d] = -1; fdone[d] = -1; tcyc[d] = -1;
         nterr[d] = 0; gapc[d] = 0; g1cyc[d] = -1; gor[d] = 2'b00;
      end
   endtask

   // Observe at negedge, advance models just after posedge
   task automatic cyc();
      @(negedge clk);
      for (int r = 0; r < 4; r++) hs[r] = rv[r/2][r%2] & rrdy[r/2][r%2];
      for (int d = 0; d < 2; d++) begin
         if (dv[d]) begin
            if (lgn[d] < 32) lg[d][lgn[d]] = txb[d];
            lgn[d]++;
            if (fdv[d] < 0) fdv[d] = cyc_n;
            ldv[d]  = cyc_n;
            dcnt[d] = ddly[d];
         end
         if (done[d] && fdone[d] < 0) fdone[d] = cyc_n;
         if (terr[d]) begin nterr[d]++; tcyc[d] = cyc_n; end
         if (bsy[d] && gnt[d] == 2'b00) gapc[d]++;
         if (gnt[d] == 2'b10 && g1cyc[d] < 0) g1cyc[d] = cyc_n;
         gor[d] |= gnt[d];
      end
      @(posedge clk);
      #1;
      cyc_n++;
      for (int r = 0; r < 4; r++) if (hs[r]) fptr[r]++;
      for (int d = 0; d < 2; d++) begin
         done[d] = 1'b0;
         if (dcnt[d] > 0) begin
            dcnt[d]--;
            if (dcnt[d] == 0 && uon[d]) done[d] = 1'b1;
         end
      end
      drive();
   endtask

   task automatic run_idle(input int d, input int maxc, input string tag);
      int n = 0;
      do begin
         cyc();
         n++;
      end while ((bsy[d] || fptr[2*d] < fcnt[2*d] || fptr[2*d+1] < fcnt[2*d+1]) && n < maxc);
      chk(tag, n < maxc, 1);
   endtask

   task automatic do_reset();
      for (int r = 0; r < 4; r++) begin fcnt[r] = 0; fptr[r] = 0; end
      for (int d = 0; d < 2; d++) begin dcnt[d] = 0; done[d] = 1'b0; end
      rst = 1'b0;
      drive();
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      clr();
   endtask

   initial begin
      total = 0; bad = 0; cyc_n = 0;
      for (int d = 0; d < 2; d++) begin uon[d] = 1'b1; ddly[d] = 10; end
      do_reset();
      rst = 1'b0;
      cyc();
      cyc();
      chk("rst_a", {gnt[0], bsy[0], dv[0], txb[0], terr[0], rrdy[0]}, 0);
      chk("rst_b", {gnt[1], bsy[1], dv[1], txb[1], terr[1], rrdy[1]}, 0);
      rst = 1'b1;
      cyc();
      clr();

      // single 9-byte frame from requester 0
      for (int i = 1; i <= 9; i++) push(0, i == 9, 8'(i));
      drive();
      s = cyc_n;
      run_idle(0, 300, "t1_end");
      chk("t1_count", lgn[0], 9);
      for (int i = 0; i < 9; i++) chk("t1_byte", lg[0][i], i + 1);
      chk("t1_grant", gor[0], 2'b01);
      chk("t1_lat_first", fdv[0] - s, 2);
      chk("t1_lat_last", ldv[0] - s, 98);

      // rr_ptr now 1: simultaneous request goes to requester 1
      clr();
      push(0, 1'b1, 8'hA9);
      push(1, 1'b1, 8'hB9);
      drive();
      run_idle(0, 200, "t1_rr_end");
      chk("t1_rr_first", lg[0][0], 8'hB9);
      chk("t1_rr_second", lg[0][1], 8'hA9);

      // contention after reset, then alternation
      do_reset();
      exp2 = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hD0};
      for (int i = 0; i < 3; i++) begin
         push(0, i == 2, exp2[i]);
         push(1, i == 2, exp2[i+3]);
      end
      drive();
      run_idle(0, 400, "t2_end");
      push(0, 1'b1, 8'hC0);
      push(1, 1'b1, 8'hD0);
      drive();
      run_idle(0, 200, "t2b_end");
      chk("t2_count", lgn[0], 8);
      for (int i = 0; i < 8; i++) chk("t2_order", lg[0][i], exp2[i]);

      // tx_done on the watchdog expiry cycle keeps the frame alive
      do_reset();
      ddly[0] = 16;
      push(0, 1'b0, 8'h81);
      push(0, 1'b1, 8'h82);
      drive();
      run_idle(0, 200, "tie_end");
      chk("tie_terr", nterr[0], 0);
      chk("tie_count", lgn[0], 2);
      chk("tie_byte", lg[0][1], 8'h82);
      ddly[0] = 10;

      // stall in LOAD: watchdog aborts, pending requester 1 takes over
      do_reset();
      push(0, 1'b0, 8'h40);
      push(1, 1'b1, 8'h50);
      drive();
      run_idle(0, 200, "t4_end");
      chk("t4_terr_cnt", nterr[0], 1);
      chk("t4_terr_time", tcyc[0] - fdone[0], 17);
      chk("t4_regrant", g1cyc[0] - tcyc[0], 1);
      chk("t4_bytes", {lg[0][0], lg[0][1]}, 16'h4050);

      // lost tx_done: abort from WAIT, no retry, rr advanced past 0
      do_reset();
      uon[0] = 1'b0;
      push(0, 1'b1, 8'h70);
      drive();
      s = cyc_n;
      run_idle(0, 100, "t5_end");
      for (int i = 0; i < 5; i++) cyc();
      chk("t5_terr_cnt", nterr[0], 1);
      chk("t5_terr_time", tcyc[0] - s, 19);
      chk("t5_dv_cnt", lgn[0], 1);
      chk("t5_busy", bsy[0], 0);
      dcnt[0] = 0;
      uon[0]  = 1'b1;
      push(0, 1'b1, 8'h74);
      push(1, 1'b1, 8'h75);
      drive();
      run_idle(0, 200, "t5b_end");
      chk("t5_rr", {lg[0][1], lg[0][2]}, 16'h7574);

      // reset in WAIT of byte 4
      do_reset();
      for (int i = 1; i <= 9; i++) push(0, i == 9, 8'(8'h10 + i));
      drive();
      for (int i = 0; i < 200 && lgn[0] < 4; i++) cyc();
      chk("t6_reach", lgn[0] >= 4, 1);
      cyc(); cyc(); cyc();
      rst = 1'b0;
      fptr[0] = fcnt[0];
      dcnt[0] = 0;
      drive();
      cyc();
      chk("t6_rst_out", {gnt[0], bsy[0], dv[0], txb[0], terr[0], rrdy[0]}, 0);
      rst = 1'b1;
      clr();
      push(1, 1'b1, 8'h61);
      drive();
      run_idle(0, 200, "t6_end");
      chk("t6_grant", gor[0], 2'b10);
      chk("t6_byte", {lgn[0][7:0], lg[0][0]}, 16'h0161);

      // gap between back-to-back frames on DUT b
      clr();
      push(3, 1'b1, 8'h31);
      push(3, 1'b1, 8'h32);
      drive();
      run_idle(1, 200, "t3_end");
      chk("t3_gap_cycles", gapc[1], 10);
      chk("t3_done_to_dv", ldv[1] - fdone[1], 8);
      chk("t3_bytes", {lgn[1][7:0], lg[1][0], lg[1][1]}, 24'h023132);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
